// File: rtl/pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
// pipelined_csel_adder : pipelined carry-select adder/subtractor with a
//                        valid/ready stream interface and overflow flag.
// Revision 1.0
// ============================================================================
module pipelined_csel_adder #(
    parameter int WIDTH       = 64,
    parameter int BLOCK_WIDTH = 16,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_cin,
    input  logic                 in_sub,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int C_BW       = (BLOCK_WIDTH < 1) ? 1 : BLOCK_WIDTH;
    localparam int NUM_BLOCKS = WIDTH / C_BW;
    localparam int C_SEG_W    = C_BW + 1;

    if ((BLOCK_WIDTH < 1) || ((WIDTH % C_BW) != 0) || (NUM_BLOCKS < 1)) begin : g_param_check
        $error("pipelined_csel_adder: WIDTH must be a non-zero multiple of BLOCK_WIDTH");
    end

    typedef logic [NUM_BLOCKS-1:0][C_SEG_W-1:0] spec_t;

    // Per-stage state: resolved low sum bits, carry out of the last resolved
    // segment, A^B of the MSB (to recover the carry into the MSB), and the
    // speculative segment pairs still waiting for their carry.
    logic [NUM_BLOCKS-1:0] r_valid;
    logic [WIDTH-1:0]      r_sum   [NUM_BLOCKS];
    logic                  r_carry [NUM_BLOCKS];
    logic                  r_axb   [NUM_BLOCKS];
    logic [TAG_WIDTH-1:0]  r_tag   [NUM_BLOCKS];
    spec_t                 r_s0    [NUM_BLOCKS];
    spec_t                 r_s1    [NUM_BLOCKS];

    logic [NUM_BLOCKS-1:0] w_n_valid;
    logic [WIDTH-1:0]      w_n_sum   [NUM_BLOCKS];
    logic                  w_n_carry [NUM_BLOCKS];
    logic                  w_n_axb   [NUM_BLOCKS];
    logic [TAG_WIDTH-1:0]  w_n_tag   [NUM_BLOCKS];
    spec_t                 w_n_s0    [NUM_BLOCKS];
    spec_t                 w_n_s1    [NUM_BLOCKS];

    logic                  r_out_valid;
    logic [WIDTH-1:0]      r_out_sum;
    logic                  r_out_cout;
    logic                  r_out_ovf;
    logic [TAG_WIDTH-1:0]  r_out_tag;

    logic                  w_stall;
    logic [WIDTH-1:0]      w_b_eff;
    logic                  w_cin_eff;
    logic                  w_ovf;

    assign w_stall   = r_out_valid && !out_ready;
    assign in_ready  = rst_n && !w_stall;
    assign w_b_eff   = in_sub ? ~in_b : in_b;
    assign w_cin_eff = in_sub | in_cin;

    for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_stage
        logic [C_SEG_W-1:0] w_sel;
        logic [WIDTH-1:0]   w_sum;
        logic               w_unused_spec;

        if (gi == 0) begin : g_first
            spec_t w_s0;
            spec_t w_s1;
            for (genvar gj = 0; gj < NUM_BLOCKS; gj++) begin : g_seg
                assign w_s0[gj] = {1'b0, in_a[gj*C_BW +: C_BW]} + {1'b0, w_b_eff[gj*C_BW +: C_BW]};
                assign w_s1[gj] = w_s0[gj] + C_SEG_W'(1);
            end
            assign w_sel = w_cin_eff ? w_s1[0] : w_s0[0];
            always_comb begin
                w_sum           = '0;
                w_sum[C_BW-1:0] = w_sel[C_BW-1:0];
            end
            assign w_n_valid[gi] = in_valid;
            assign w_n_axb[gi]   = in_a[WIDTH-1] ^ w_b_eff[WIDTH-1];
            assign w_n_tag[gi]   = in_tag;
            assign w_n_s0[gi]    = w_s0;
            assign w_n_s1[gi]    = w_s1;
        end else begin : g_next
            assign w_sel = r_carry[gi-1] ? r_s1[gi-1][gi] : r_s0[gi-1][gi];
            always_comb begin
                w_sum                   = r_sum[gi-1];
                w_sum[gi*C_BW +: C_BW]  = w_sel[C_BW-1:0];
            end
            assign w_n_valid[gi] = r_valid[gi-1];
            assign w_n_axb[gi]   = r_axb[gi-1];
            assign w_n_tag[gi]   = r_tag[gi-1];
            assign w_n_s0[gi]    = r_s0[gi-1];
            assign w_n_s1[gi]    = r_s1[gi-1];
        end

        assign w_n_sum[gi]   = w_sum;
        assign w_n_carry[gi] = w_sel[C_BW];
        // Already-resolved segments of a pair are carried but never read again.
        assign w_unused_spec = ^{r_s0[gi], r_s1[gi]};
    end

    // Carry into the MSB is sum_msb ^ a_msb ^ b_msb; overflow compares it with cout.
    assign w_ovf = r_sum[NUM_BLOCKS-1][WIDTH-1] ^ r_axb[NUM_BLOCKS-1] ^ r_carry[NUM_BLOCKS-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_sum[i]   <= '0;
                r_carry[i] <= 1'b0;
                r_axb[i]   <= 1'b0;
                r_tag[i]   <= '0;
                r_s0[i]    <= '0;
                r_s1[i]    <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_tag   <= '0;
        end else if (!w_stall) begin
            r_valid <= w_n_valid;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                if (w_n_valid[i]) begin
                    r_sum[i]   <= w_n_sum[i];
                    r_carry[i] <= w_n_carry[i];
                    r_axb[i]   <= w_n_axb[i];
                    r_tag[i]   <= w_n_tag[i];
                    r_s0[i]    <= w_n_s0[i];
                    r_s1[i]    <= w_n_s1[i];
                end
            end
            r_out_valid <= r_valid[NUM_BLOCKS-1];
            if (r_valid[NUM_BLOCKS-1]) begin
                r_out_sum  <= r_sum[NUM_BLOCKS-1];
                r_out_cout <= r_carry[NUM_BLOCKS-1];
                r_out_ovf  <= w_ovf;
                r_out_tag  <= r_tag[NUM_BLOCKS-1];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_ovf   = r_out_ovf;
    assign out_tag   = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
// tb_pipelined_csel_adder : randomized stream bench with an arithmetic model
// Revision 1.0
// ============================================================================
module tb_pipelined_csel_adder;

    localparam int W  = 64;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic [3:0]    in_tag = '0;
    logic          in_ready, out_valid, out_cout, out_ovf;
    logic [W-1:0]  out_sum;
    logic [3:0]    out_tag;

    // Secondary instances for other geometries.
    logic          v48 = 1'b0, rdy48, ov48, co48, of48;
    logic [47:0]   a48 = '0, b48 = '0, s48;
    logic          cin48 = 1'b0;
    logic [3:0]    t48;
    logic          v32 = 1'b0, rdy32, ov32, co32, of32;
    logic [31:0]   a32 = '0, b32 = '0, s32;
    logic [3:0]    t32;

    always #5 clk = ~clk;

    pipelined_csel_adder #(.WIDTH(64), .BLOCK_WIDTH(16), .TAG_WIDTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag));

    pipelined_csel_adder #(.WIDTH(48), .BLOCK_WIDTH(16), .TAG_WIDTH(4)) u_dut48 (
        .clk(clk), .rst_n(rst_n), .in_valid(v48), .in_ready(rdy48),
        .in_a(a48), .in_b(b48), .in_cin(cin48), .in_sub(1'b0), .in_tag(4'd0),
        .out_valid(ov48), .out_ready(1'b1), .out_sum(s48),
        .out_cout(co48), .out_ovf(of48), .out_tag(t48));

    pipelined_csel_adder #(.WIDTH(32), .BLOCK_WIDTH(32), .TAG_WIDTH(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
        .in_a(a32), .in_b(b32), .in_cin(1'b0), .in_sub(1'b0), .in_tag(4'd0),
        .out_valid(ov32), .out_ready(1'b1), .out_sum(s32),
        .out_cout(co32), .out_ovf(of32), .out_tag(t32));

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [3:0]   tag;
        int           acc_cyc;
        int           acc_stall;
    } exp_t;

    exp_t q[$];
    int   errors = 0, checks = 0;
    int   cyc = 0, stall_cnt = 0, n_out = 0;
    logic [W-1:0] last_sum;
    logic         last_cout, last_ovf;
    logic [3:0]   last_tag;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain two's-complement arithmetic: A + B + cin, or A - B.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input logic [3:0] tag);
        exp_t e;
        logic [W:0]   full;
        logic [W-1:0] be;
        be     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == be[W-1]) && (e.sum[W-1] != a[W-1]);
        e.tag  = tag;
        e.acc_cyc = 0;
        e.acc_stall = 0;
        return e;
    endfunction

    // Compare process: samples between edges the values the next rising edge will see.
    logic          have_hold = 1'b0;
    logic [69:0]   hold_vec;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                q.delete();
                have_hold = 1'b0;
                chk("in_ready_in_reset", in_ready, 0);
            end else begin
                chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
                if (have_hold)
                    chk("hold_stable", {out_valid, out_sum, out_cout, out_ovf, out_tag}, {1'b1, hold_vec});
                have_hold = out_valid && !out_ready;
                hold_vec  = {out_sum, out_cout, out_ovf, out_tag};
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_out", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("sum", out_sum, e.sum);
                        chk("cout_ovf_tag", {out_cout, out_ovf, out_tag}, {e.cout, e.ovf, e.tag});
                        chk("latency", cyc - e.acc_cyc - 1 - (stall_cnt - e.acc_stall), NB);
                    end
                    n_out++;
                    last_sum = out_sum; last_cout = out_cout; last_ovf = out_ovf; last_tag = out_tag;
                end
                if (out_valid && !out_ready) stall_cnt++;
                if (in_valid && in_ready) begin
                    exp_t e;
                    e = model(in_a, in_b, in_cin, in_sub, in_tag);
                    e.acc_cyc = cyc;
                    e.acc_stall = stall_cnt;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [3:0] tag);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
        #1;
        while (!in_ready) begin
            if (n++ > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stuck at 0, required 1");
                break;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int prev);
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            #3;
            if (n_out > prev) break;
        end
        if (k == 60) begin
            checks++; errors++;
            $display("FAIL result_timeout: no result, required one");
        end
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            #3;
            if (q.size() == 0 && !out_valid) break;
        end
        chk("drained", q.size(), 0);
    endtask

    initial begin
        exp_t m;
        int   prev, lat;

        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t m;
        int   prev, lat;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("reset_vals", {out_valid, out_sum, out_cout, out_ovf, out_tag}, 0);

        // Full ripple through every segment.
        m = model(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 4'd3);
        chk("model_ripple", {m.sum, m.cout, m.ovf}, {64'h0, 1'b1, 1'b0});
        prev = n_out;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 4'd3);
        idle();
        wait_result(prev);
        chk("ripple_dut", {last_sum, last_cout, last_ovf, last_tag}, {64'h0, 1'b1, 1'b0, 4'd3});

        m = model(64'd5, 64'd7, 1'b0, 1'b1, 4'd1);
        chk("model_sub_neg", {m.sum, m.cout, m.ovf}, {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        prev = n_out;
        send(64'd5, 64'd7, 1'b1, 1'b1, 4'd1);
        idle();
        wait_result(prev);
        chk("sub_neg_dut", {last_sum, last_cout, last_ovf}, {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});

        m = model(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 4'd2);
        chk("model_sub_ovf", {m.sum, m.cout, m.ovf}, {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});
        prev = n_out;
        send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 4'd2);
        idle();
        wait_result(prev);
        chk("sub_ovf_dut", {last_sum, last_cout, last_ovf}, {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});

        // Back-to-back streaming with out_ready held high.
        for (int i = 0; i < 32; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 4'(i));
        idle();
        drain();

        // Explicit backpressure: 4 beats in flight, out_ready low for 3 cycles.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 4'(i + 8));
        idle();
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Random backpressure with random input gaps.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send({$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                         : {$urandom, $urandom}, 1'($urandom), 1'($urandom), 4'($urandom));
                    if ($urandom_range(0, 3) == 0) idle();
                end
                idle();
            end
            begin
                repeat (150) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight: none of them may emerge.
        for (int i = 0; i < 3; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 4'(i + 5));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("mid_reset_vals", {out_valid, out_sum, out_cout, out_ovf, out_tag}, 0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 6; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 4'(i));
        idle();
        drain();

        // WIDTH=48, BLOCK_WIDTH=16: latency 3, carry crossing segments.
        @(negedge clk);
        v48 = 1'b1; a48 = 48'h0000_FFFF_FFFF; b48 = 48'h0; cin48 = 1'b1;
        #1;
        chk("rdy48", rdy48, 1);
        @(negedge clk);
        v48 = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (ov48) begin lat = k; break; end
            @(negedge clk);
        end
        chk("lat48", lat, 3);
        chk("sum48", {s48, co48, of48}, {48'h0001_0000_0000, 1'b0, 1'b0});

        // WIDTH=32, BLOCK_WIDTH=32: latency 1, overflow into the sign bit.
        @(negedge clk);
        v32 = 1'b1; a32 = 32'h7FFF_FFFF; b32 = 32'd1;
        #1;
        chk("rdy32", rdy32, 1);
        @(negedge clk);
        v32 = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (ov32) begin lat = k; break; end
            @(negedge clk);
        end
        chk("lat32", lat, 1);
        chk("sum32", {s32, co32, of32}, {32'h8000_0000, 1'b0, 1'b1});

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
